// File: rtl/axi_rd_pkg.sv
// Shared types and default widths for the AXI read-channel memory responder.
// Request records carry everything needed to replay a burst from the queue head.
package axi_rd_pkg;

  localparam int unsigned AddrBits      = 64;
  localparam int unsigned BurstLenWidth = 8;
  localparam int unsigned TidWidth      = 8;
  localparam int unsigned DataBits      = 64;
  localparam int unsigned LogQueueSize  = 2;
  localparam int unsigned LatencyWidth  = 8;
  localparam int unsigned BeatBytes     = DataBits / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } rsp_state_t;

  typedef struct packed {
    logic [AddrBits-1:0]      addr;
    logic [BurstLenWidth-1:0] len;
    logic [TidWidth-1:0]      id;
  } ar_req_t;

  // Address of beat idx within a burst; wraps silently at the top of the address space.
  function automatic logic [AddrBits-1:0] beat_addr(input logic [AddrBits-1:0]      base,
                                                    input logic [BurstLenWidth-1:0] idx);
    return base + (AddrBits'(idx) << $clog2(BeatBytes));
  endfunction

endpackage

// File: rtl/ar_req_fifo.sv
// In-order queue of accepted read requests; the head stays put until the
// responder has streamed every beat of that burst.
module ar_req_fifo
  import axi_rd_pkg::*;
#(
  parameter int unsigned LogDepth = LogQueueSize
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  ar_req_t         push_req,
  input  logic            pop,
  output ar_req_t         head,
  output logic            full,
  output logic            empty,
  output logic [LogDepth:0] count
);

  localparam int unsigned Depth = 2 ** LogDepth;

  ar_req_t             mem [Depth];
  logic [LogDepth:0]   wr_ptr_q;
  logic [LogDepth:0]   rd_ptr_q;
  logic                do_push;
  logic                do_pop;

  // Extra pointer MSB distinguishes a full queue from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[LogDepth] != rd_ptr_q[LogDepth]) &&
                 (wr_ptr_q[LogDepth-1:0] == rd_ptr_q[LogDepth-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem[rd_ptr_q[LogDepth-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (LogDepth + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (LogDepth + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[LogDepth-1:0]] <= push_req;
  end

endmodule

// File: rtl/axi_rd_mem_responder.sv
// AXI4 read responder: queues AR requests and replays each as len+1 R beats
// whose data is the beat address, after a programmable start-up latency.
module axi_rd_mem_responder
  import axi_rd_pkg::*;
#(
  parameter int unsigned ADDR_BITS       = AddrBits,
  parameter int unsigned BURST_LEN_WIDTH = BurstLenWidth,
  parameter int unsigned TID_WIDTH       = TidWidth,
  parameter int unsigned DATA_BITS       = DataBits,
  parameter int unsigned LOG_QUEUE_SIZE  = LogQueueSize,
  parameter int unsigned LATENCY_WIDTH   = LatencyWidth
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_ar_valid,
  output logic                       s_ar_ready,
  input  logic [ADDR_BITS-1:0]       s_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
  input  logic [TID_WIDTH-1:0]       s_ar_id,
  output logic                       s_r_valid,
  input  logic                       s_r_ready,
  output logic [DATA_BITS-1:0]       s_r_data,
  output logic [TID_WIDTH-1:0]       s_r_id,
  output logic                       s_r_last,
  input  logic [LATENCY_WIDTH-1:0]   rdLatency,
  output logic [LOG_QUEUE_SIZE:0]    pendingCnt
);

  ar_req_t                    push_req;
  ar_req_t                    head;
  logic                       push;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [LOG_QUEUE_SIZE:0]    count;

  rsp_state_t                 state_q;
  logic [LATENCY_WIDTH-1:0]   lat_cnt_q;
  logic [BURST_LEN_WIDTH-1:0] beat_cnt_q;
  logic [BURST_LEN_WIDTH-1:0] load_cnt;
  logic                       r_valid_q;
  logic                       r_last_q;
  logic [DATA_BITS-1:0]       r_data_q;
  logic [TID_WIDTH-1:0]       r_id_q;

  assign s_ar_ready = !full;
  assign push       = s_ar_valid && !full;

  assign push_req.addr = s_ar_addr;
  assign push_req.len  = s_ar_len;
  assign push_req.id   = s_ar_id;

  ar_req_fifo #(
    .LogDepth (LOG_QUEUE_SIZE)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // Head leaves the queue only once its final beat is handed off.
  assign pop = (state_q == BURST) && r_valid_q && s_r_ready && r_last_q;

  // Beat to load into the output register: the first beat on BURST entry,
  // otherwise the successor of the beat just accepted.
  assign load_cnt = r_valid_q ? beat_cnt_q + BURST_LEN_WIDTH'(1) : beat_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      beat_cnt_q <= '0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_data_q   <= '0;
      r_id_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            lat_cnt_q  <= rdLatency;
            beat_cnt_q <= '0;
            state_q    <= (rdLatency != '0) ? WAIT : BURST;
          end
        end
        WAIT: begin
          lat_cnt_q <= lat_cnt_q - LATENCY_WIDTH'(1);
          if (lat_cnt_q == LATENCY_WIDTH'(1)) state_q <= BURST;
        end
        BURST: begin
          if (r_valid_q && s_r_ready && r_last_q) begin
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            state_q   <= IDLE;
          end else if (!r_valid_q || s_r_ready) begin
            // Outputs change only when nothing is presented or the beat was taken.
            beat_cnt_q <= load_cnt;
            r_valid_q  <= 1'b1;
            r_data_q   <= DATA_BITS'(beat_addr(head.addr, load_cnt));
            r_id_q     <= head.id;
            r_last_q   <= (load_cnt == head.len);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_r_valid  = r_valid_q;
  assign s_r_data   = r_data_q;
  assign s_r_id     = r_id_q;
  assign s_r_last   = r_last_q;
  assign pendingCnt = count;

endmodule

// File: doc/axi_rd_mem_responder.md
# axi_rd_mem_responder

AXI4 read-channel responder modelling the DDR side of the prefetcher's master port. Accepts read requests on AR, queues them in order, and after a programmable latency returns `len+1` R beats per request with the request's ID and deterministic, address-derived data. Drives the prefetcher's `m_ar_*`/`m_r_*` interface in system simulation and stands in as a memory stub for FPGA bring-up.

## Interface
- `ADDR_BITS`, 64, request address width
- `BURST_LEN_WIDTH`, 8, AXI `len` width
- `TID_WIDTH`, 8, transaction ID width
- `DATA_BITS`, 64, R data width; beat size `BEAT_BYTES = DATA_BITS/8`
- `LOG_QUEUE_SIZE`, 2, request queue depth `2^LOG_QUEUE_SIZE`
- `LATENCY_WIDTH`, 8, width of `rdLatency`

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `s_ar_valid`  in  1  request valid
- `s_ar_ready`  out  1  request accept, `= !full`
- `s_ar_addr`  in  ADDR_BITS  burst start address
- `s_ar_len`  in  BURST_LEN_WIDTH  beats minus one
- `s_ar_id`  in  TID_WIDTH  transaction ID
- `s_r_valid`  out  1  beat valid
- `s_r_ready`  in  1  beat accept
- `s_r_data`  out  DATA_BITS  beat data
- `s_r_id`  out  TID_WIDTH  ID of current burst
- `s_r_last`  out  1  final beat of burst
- `rdLatency`  in  LATENCY_WIDTH  idle cycles inserted before first beat
- `pendingCnt`  out  LOG_QUEUE_SIZE+1  queued requests incl. the one being served

## Operation
- AR handshake (`s_ar_valid && s_ar_ready`) pushes {addr,len,id} into FIFO. Push when full impossible (`s_ar_ready=0`).
- FSM: `IDLE`, `WAIT`, `BURST`.
  - `IDLE`: FIFO non-empty → load `latCnt=rdLatency`, `beatCnt=0`; go `WAIT` if `rdLatency!=0`, else `BURST`.
  - `WAIT`: decrement `latCnt`; at 1 → `BURST`. `rdLatency` sampled only on IDLE exit; later changes ignored.
  - `BURST`: `s_r_valid=1`. On `s_r_valid && s_r_ready`: if `beatCnt==len` pop FIFO, → `IDLE`; else `beatCnt++`.
- Beat data: `beatAddr = addr + beatCnt*BEAT_BYTES`, modulo 2^ADDR_BITS (wrap, no error); `s_r_data` = `beatAddr` zero-extended or truncated to DATA_BITS.
- `s_r_id` = head ID; `s_r_last = (beatCnt==len)` while in `BURST`, else 0.
- Strictly in-order; one burst in flight on R.
- `len=2^BURST_LEN_WIDTH-1` gives 256 beats; `beatCnt` is BURST_LEN_WIDTH wide, no overflow.
- Push and pop in the same cycle allowed; `pendingCnt` unchanged.

## Timing
- Reset values: `s_ar_ready=1`, `s_r_valid=0`, `s_r_last=0`, `s_r_data=0`, `s_r_id=0`, `pendingCnt=0`, FSM `IDLE`, FIFO empty.
- Reset mid-burst or mid-wait: all state cleared at that edge; queued requests dropped; `s_r_valid=0` the following cycle.
- Latency: AR handshake at edge k → `s_r_valid` first high after edge `k+2+rdLatency`, if queue was empty and FSM idle.
- Back-to-back bursts: after last beat accepted at edge j, next burst's first beat earliest after edge `j+2` (one IDLE bubble). This is deliberate.
- R rule: once `s_r_valid=1`, valid, data, id, and last hold stable until `s_r_ready`. Backpressure of any length is allowed.
- `s_ar_ready` is combinational from registered FIFO count only; no path from `s_ar_valid`.
- `pendingCnt` is registered and updates the cycle after push/pop.

## Structure
- Package `axi_rd_pkg`:
  - `rsp_state_t` enum {IDLE, WAIT, BURST}.
  - `ar_req_t` struct {addr, len, id}, parameterised via package localparams matching the defaults above.
- Sub-module `ar_req_fifo`:
  - Synchronous FIFO of `ar_req_t`, depth `2^LOG_QUEUE_SIZE`.
  - Ports: push, pop, head, full, empty, count.
  - Wrap-around pointers with an extra MSB for full/empty.
- Top holds the FSM, `latCnt`, `beatCnt`, and data generation.

## Test plan
- Single burst:
  - Stimulus: reset, `rdLatency=3`, AR {addr=0xdeadbeef, len=4, id=3}, `s_r_ready=1`.
  - Response: first `s_r_valid` 5 cycles after handshake; 5 beats with data 0xdeadbeef, 0xdeadbef7, … 0xdeadbf0f; `s_r_id=3`; `s_r_last` only on beat 5.
- Queue full:
  - Stimulus: `s_r_ready=0`, 5 back-to-back ARs (depth 4).
  - Response: 4 accepted; `s_ar_ready=0` from the cycle after the 4th push; `pendingCnt=4`.
  - Then: releasing `s_r_ready` drains bursts in order with IDs 0, 1, 2, 3.
- Backpressure:
  - Stimulus: `len=2`; toggle `s_r_ready` 1, 0, 0, 1, 0, 1.
  - Response: data/id/last stable during stalls; exactly 3 beats accepted.
- Zero latency and wrap:
  - Stimulus: `rdLatency=0`, addr=0xffff_ffff_ffff_fff8, `len=1`.
  - Response: first beat 2 cycles after handshake; beat data 0xffff_ffff_ffff_fff8, then 0x0.
- Reset mid-burst:
  - Stimulus: assert `reset` during beat 2 of a `len=7` burst with 2 requests queued.
  - Response: `s_r_valid=0`, `pendingCnt=0`, `s_ar_ready=1` next cycle; no further beats.
